// File: rtl/ber_checker_if.sv
// Sample-in / decision-and-measurement-out bundle for the BER checker.
interface ber_checker_if;
  logic signed [11:0] rx_I;
  logic signed [11:0] rx_Q;
  logic               rx_valid;
  logic               meas_clr;
  logic [3:0]         dec_bits;
  logic               dec_valid;
  logic               locked;
  logic [31:0]        ber_bits;
  logic [31:0]        ber_errors;
  logic               result_valid;
  logic [15:0]        sync_loss_cnt;

  modport master (
    output rx_I, rx_Q, rx_valid, meas_clr,
    input  dec_bits, dec_valid, locked, ber_bits, ber_errors, result_valid, sync_loss_cnt
  );

  modport slave (
    input  rx_I, rx_Q, rx_valid, meas_clr,
    output dec_bits, dec_valid, locked, ber_bits, ber_errors, result_valid, sync_loss_cnt
  );
endinterface

// File: rtl/ber_checker.sv
// 16-QAM hard slicer followed by a self-synchronising PRBS-15 bit-error-rate counter.
module ber_checker #(
  parameter int THRESH      = 1024,
  parameter int VERIFY_SYMS = 16,
  parameter int LOSS_BLOCK  = 32,
  parameter int LOSS_THRESH = 32,
  parameter int WINDOW_SYMS = 65536
) (
  input logic           clk,
  input logic           rst_n,
  ber_checker_if.slave  bus
);

  localparam int DATA_W = 12;
  localparam logic signed [DATA_W-1:0] POS_TH = DATA_W'(THRESH);
  localparam logic signed [DATA_W-1:0] NEG_TH = DATA_W'(-THRESH);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic [1:0] slice(input logic signed [DATA_W-1:0] x);
    if (x <= NEG_TH)      return 2'b00;
    else if (x[DATA_W-1]) return 2'b01;
    else if (x < POS_TH)  return 2'b11;
    else                  return 2'b10;
  endfunction

  // Newest bit lands in [0]; after four steps [3:0] holds the next symbol, oldest first.
  function automatic logic [14:0] prbs_adv4(input logic [14:0] s);
    logic [14:0] r;
    r = s;
    for (int k = 0; k < 4; k++) r = {r[13:0], r[14] ^ r[13]};
    return r;
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // ---- stage 1: slicer
  logic [3:0] dec_bits_p1;
  logic       vld_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_bits_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= bus.rx_valid;
      if (bus.rx_valid) dec_bits_p1 <= {slice(bus.rx_I), slice(bus.rx_Q)};
    end
  end

  // ---- stage 2: reference compare, sync FSM, accumulators
  state_t      state_p2, state_nx;
  logic [14:0] prbs_p2, pred;
  logic [3:0]  err_vec;
  logic [2:0]  err_pc;
  logic        mism, blk_end, loss_evt, win_end, res_vld_p2;
  logic [1:0]  hunt_cnt_p2;
  logic [15:0] ver_cnt_p2, blk_cnt_p2, blk_err_p2, blk_err_sum, loss_cnt_p2;
  logic [31:0] win_cnt_p2, acc_bits_p2, acc_err_p2, bits_sum, err_sum;
  logic [31:0] ber_bits_p2, ber_errors_p2;

  always_comb begin
    pred        = prbs_adv4(prbs_p2);
    err_vec     = pred[3:0] ^ dec_bits_p1;
    err_pc      = popcnt4(err_vec);
    mism        = |err_vec;
    blk_end     = (blk_cnt_p2 == 16'(LOSS_BLOCK - 1));
    blk_err_sum = blk_err_p2 + 16'(err_pc);
    win_end     = (win_cnt_p2 == 32'(WINDOW_SYMS - 1));
    bits_sum    = acc_bits_p2;
    err_sum     = acc_err_p2;
    if (state_p2 == LOCKED) begin
      bits_sum = sat_add32(acc_bits_p2, 32'd4);
      err_sum  = sat_add32(acc_err_p2, 32'(err_pc));
    end
  end

  always_comb begin
    state_nx = state_p2;
    loss_evt = 1'b0;
    if (vld_p1) begin
      unique case (state_p2)
        HUNT:    if (hunt_cnt_p2 == 2'd3) state_nx = VERIFY;
        VERIFY:  if (mism) state_nx = HUNT;
                 else if (ver_cnt_p2 == 16'(VERIFY_SYMS - 1)) state_nx = LOCKED;
        LOCKED:  if (blk_end && (blk_err_sum > 16'(LOSS_THRESH))) begin
                   state_nx = HUNT;
                   loss_evt = 1'b1;
                 end
        default: state_nx = HUNT;
      endcase
    end
    if (bus.meas_clr) begin
      state_nx = HUNT;
      loss_evt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p2 <= HUNT;
    else        state_p2 <= state_nx;
  end

  // A failed VERIFY symbol leaves the reference untouched; HUNT reloads it anyway.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      if (state_p2 == HUNT)                      prbs_p2 <= {prbs_p2[10:0], dec_bits_p1};
      else if (state_p2 == LOCKED || !mism)      prbs_p2 <= pred;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hunt_cnt_p2   <= '0;
      ver_cnt_p2    <= '0;
      blk_cnt_p2    <= '0;
      blk_err_p2    <= '0;
      loss_cnt_p2   <= '0;
      win_cnt_p2    <= '0;
      acc_bits_p2   <= '0;
      acc_err_p2    <= '0;
      ber_bits_p2   <= '0;
      ber_errors_p2 <= '0;
      res_vld_p2    <= 1'b0;
    end else begin
      res_vld_p2 <= 1'b0;
      if (bus.meas_clr) begin
        hunt_cnt_p2 <= '0;
        ver_cnt_p2  <= '0;
        blk_cnt_p2  <= '0;
        blk_err_p2  <= '0;
        loss_cnt_p2 <= '0;
        win_cnt_p2  <= '0;
        acc_bits_p2 <= '0;
        acc_err_p2  <= '0;
      end else if (vld_p1) begin
        if (state_p2 == HUNT) hunt_cnt_p2 <= hunt_cnt_p2 + 2'd1;
        ver_cnt_p2 <= (state_p2 == VERIFY && state_nx == VERIFY) ? ver_cnt_p2 + 16'd1 : 16'd0;
        if (state_p2 == LOCKED && !blk_end) begin
          blk_cnt_p2 <= blk_cnt_p2 + 16'd1;
          blk_err_p2 <= blk_err_sum;
        end else begin
          blk_cnt_p2 <= '0;
          blk_err_p2 <= '0;
        end
        if (loss_evt && loss_cnt_p2 != 16'hFFFF) loss_cnt_p2 <= loss_cnt_p2 + 16'd1;
        if (win_end) begin
          ber_bits_p2   <= bits_sum;
          ber_errors_p2 <= err_sum;
          res_vld_p2    <= 1'b1;
          acc_bits_p2   <= '0;
          acc_err_p2    <= '0;
          win_cnt_p2    <= '0;
        end else begin
          acc_bits_p2 <= bits_sum;
          acc_err_p2  <= err_sum;
          win_cnt_p2  <= win_cnt_p2 + 32'd1;
        end
      end
    end
  end

  assign bus.dec_bits      = dec_bits_p1;
  assign bus.dec_valid     = vld_p1;
  assign bus.locked        = (state_p2 == LOCKED);
  assign bus.ber_bits      = ber_bits_p2;
  assign bus.ber_errors    = ber_errors_p2;
  assign bus.result_valid  = res_vld_p2;
  assign bus.sync_loss_cnt = loss_cnt_p2;

endmodule

// File: tb/tb_ber_checker.sv
// Bench for ber_checker: slicer table, PRBS acquisition, window accounting, loss, clear and reset.
module tb_ber_checker;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ber_checker_if bus();

  ber_checker #(
    .THRESH(1024), .VERIFY_SYMS(16), .LOSS_BLOCK(32), .LOSS_THRESH(32), .WINDOW_SYMS(256)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  sb[$];
  logic        lk_hist[$];
  logic [31:0] res_bits[$];
  logic [31:0] res_errs[$];
  bit          pw[$];
  logic        exp_vld;

  typedef struct {
    logic signed [11:0] i;
    logic signed [11:0] q;
    logic [3:0]         exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // dec_valid must be rx_valid delayed by one clock
  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_vld <= 1'b0;
    else        exp_vld <= bus.rx_valid;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("dec_valid_latency", bus.dec_valid, exp_vld);
      if (bus.dec_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dec_bits_unexpected: got %h, expected no symbol", bus.dec_bits);
        end else begin
          chk("dec_bits", bus.dec_bits, sb.pop_front());
        end
      end
      if (bus.result_valid) begin
        res_bits.push_back(bus.ber_bits);
        res_errs.push_back(bus.ber_errors);
      end
    end
  end

  function automatic logic signed [11:0] lvl(input logic [1:0] b);
    case (b)
      2'b00:   return -12'sd1536;
      2'b01:   return -12'sd512;
      2'b11:   return 12'sd512;
      default: return 12'sd1536;
    endcase
  endfunction

  task automatic reseed();
    logic [14:0] s;
    s = 15'($urandom_range(1, 32767));
    pw.delete();
    for (int k = 0; k < 15; k++) pw.push_back(s[k]);
  endtask

  // pw[0] is b[n-15], pw[1] is b[n-14]
  task automatic next_sym(output logic [3:0] sym);
    bit nb;
    sym = 4'd0;
    for (int k = 0; k < 4; k++) begin
      nb = pw[0] ^ pw[1];
      pw.push_back(nb);
      void'(pw.pop_front());
      sym = {sym[2:0], nb};
    end
  endtask

  task automatic drive(input logic v, input logic signed [11:0] i, input logic signed [11:0] q,
                       input logic clr, input logic [3:0] e);
    @(posedge clk);
    #1;
    lk_hist.push_back(bus.locked);
    bus.rx_valid = v;
    bus.rx_I     = i;
    bus.rx_Q     = q;
    bus.meas_clr = clr;
    if (v) sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic clr);
    for (int k = 0; k < n; k++) drive(1'b0, 12'sd0, 12'sd0, clr, 4'd0);
  endtask

  task automatic send_prbs(input logic [3:0] flip);
    logic [3:0] s;
    next_sym(s);
    s = s ^ flip;
    drive(1'b1, lvl(s[3:2]), lvl(s[1:0]), 1'b0, s);
  endtask

  task automatic send_rand();
    logic [3:0] s;
    s = 4'($urandom_range(0, 15));
    drive(1'b1, lvl(s[3:2]), lvl(s[1:0]), 1'b0, s);
  endtask

  // New start phase, one full window, and the lock edge at symbol 20
  task automatic acquire_window(input string tag);
    reseed();
    lk_hist.delete();
    for (int k = 0; k < 256; k++) send_prbs(4'd0);
    chk({tag, "_unlocked_sym19"}, lk_hist[20], 1'b0);
    chk({tag, "_locked_sym20"}, lk_hist[21], 1'b1);
  endtask

  task automatic chk_res(input string tag, input int k, input logic [31:0] eb, input logic [31:0] ee);
    chk({tag, "_count"}, res_bits.size(), k + 1);
    if (res_bits.size() > k) begin
      chk({tag, "_bits"}, res_bits[k], eb);
      chk({tag, "_errors"}, res_errs[k], ee);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dec_bits"}, bus.dec_bits, 4'd0);
    chk({tag, "_dec_valid"}, bus.dec_valid, 1'b0);
    chk({tag, "_locked"}, bus.locked, 1'b0);
    chk({tag, "_ber_bits"}, bus.ber_bits, 32'd0);
    chk({tag, "_ber_errors"}, bus.ber_errors, 32'd0);
    chk({tag, "_result_valid"}, bus.result_valid, 1'b0);
    chk({tag, "_sync_loss"}, bus.sync_loss_cnt, 16'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[16];
    int          vals[7];
    logic [1:0]  ib[7];
    int          f;
    logic        relock;
    logic        held;

    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_I     = 12'sd0;
    bus.rx_Q     = 12'sd0;
    bus.meas_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_zero("reset");

    vals = '{-1025, -1024, -1023, -1, 0, 1023, 1024};
    ib   = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};
    for (int k = 0; k < 7; k++) begin
      vt[k].i       = 12'(vals[k]);
      vt[k].q       = 12'sd0;
      vt[k].exp     = {ib[k], 2'b11};
      vt[7 + k].i   = 12'sd0;
      vt[7 + k].q   = 12'(vals[k]);
      vt[7 + k].exp = {2'b11, ib[k]};
    end
    vt[14].i = -12'sd2048; vt[14].q = 12'sd2047;  vt[14].exp = 4'b0010;
    vt[15].i = 12'sd2047;  vt[15].q = -12'sd2048; vt[15].exp = 4'b1000;
    for (int k = 0; k < 16; k++) drive(1'b1, vt[k].i, vt[k].q, 1'b0, vt[k].exp);
    idle(3, 1'b0);
    chk("slicer_drained", sb.size(), 0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Clean acquisition, then two more clean windows, the last with 10 single-bit errors
    acquire_window("acq1");
    idle(3, 1'b0);
    chk_res("win1", 0, 32'd944, 32'd0);
    for (int k = 0; k < 256; k++) send_prbs(4'd0);
    idle(3, 1'b0);
    chk_res("win2", 1, 32'd1024, 32'd0);
    lk_hist.delete();
    for (int k = 0; k < 256; k++)
      send_prbs((k % 25 == 5 && k < 250) ? 4'(1 << (k % 4)) : 4'd0);
    idle(3, 1'b0);
    chk_res("win3", 2, 32'd1024, 32'd10);
    held = 1'b1;
    foreach (lk_hist[i]) held &= lk_hist[i];
    chk("win3_locked_held", held, 1'b1);

    // Random data: drop out at a 32-symbol block end and never relock
    lk_hist.delete();
    for (int k = 0; k < 200; k++) send_rand();
    idle(3, 1'b0);
    chk("loss_count", bus.sync_loss_cnt, 16'd1);
    chk("loss_unlocked", bus.locked, 1'b0);
    f = -1;
    foreach (lk_hist[i]) if (f < 0 && !lk_hist[i]) f = i;
    relock = 1'b0;
    if (f >= 0) for (int i = f; i < lk_hist.size(); i++) if (lk_hist[i]) relock = 1'b1;
    chk("loss_not_early", (f >= 21), 1'b1);
    if (f >= 21) chk("loss_at_block_end", (f - 21) % 32, 0);
    chk("loss_no_relock", relock, 1'b0);

    idle(1, 1'b1);
    idle(2, 1'b0);
    chk("clr_sync_loss", bus.sync_loss_cnt, 16'd0);
    chk("clr_locked", bus.locked, 1'b0);

    acquire_window("acq2");
    idle(3, 1'b0);
    chk_res("win4", 3, 32'd944, 32'd0);

    // Asynchronous reset between clock edges
    for (int k = 0; k < 100; k++) send_prbs(4'd0);
    @(posedge clk);
    #1;
    chk("pre_reset_locked", bus.locked, 1'b1);
    chk("pre_reset_dec_valid", bus.dec_valid, 1'b1);
    bus.rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    idle(2, 1'b0);

    // meas_clr lands on the stage-2 cycle of the window's last symbol
    reseed();
    lk_hist.delete();
    for (int k = 0; k < 256; k++) send_prbs(4'd0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    chk("clrwin_had_locked", lk_hist[21], 1'b1);
    chk("clrwin_no_pulse", res_bits.size(), 4);
    chk("clrwin_ber_bits", bus.ber_bits, 32'd0);
    chk("clrwin_ber_errors", bus.ber_errors, 32'd0);
    chk("clrwin_locked", bus.locked, 1'b0);

    acquire_window("acq3");
    idle(3, 1'b0);
    chk_res("win5", 4, 32'd944, 32'd0);
    chk("final_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
